// File: rtl/pwm_deadband.sv
// Dead-banded complementary PWM from an upstream triangle carrier: raw = tri_in < duty_active, duty swapped at the valley.
// Outputs are registered one edge after raw; no backpressure. DEADBAND_DEADTIME_EN enables the dead-time FSM.
module pwm_deadband #(
  parameter int N = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] tri_in,
  input  logic [N-1:0] duty_in,
  input  logic         duty_load,
  input  logic [D-1:0] dead_time,
  output logic         duty_busy,
  output logic         period_tick,
  output logic         out_hi,
  output logic         out_lo
);

  logic [N-1:0] duty_pend_q, duty_pend_d;
  logic [N-1:0] duty_active_q, duty_active_d;
  logic         duty_busy_q, duty_busy_d;
  logic         period_tick_q, period_tick_d;
  logic         raw;
  logic         xfer;

  assign raw  = tri_in < duty_active_q;
  // Only swap duty at the carrier valley so a period never sees two thresholds.
  assign xfer = duty_busy_q & ena & (tri_in == '0);

  always_comb begin
    duty_pend_d   = duty_pend_q;
    duty_active_d = duty_active_q;
    duty_busy_d   = duty_busy_q;
    period_tick_d = xfer;
    if (xfer) begin
      duty_active_d = duty_pend_q;
    end
    if (duty_load) begin
      duty_pend_d = duty_in;
      duty_busy_d = 1'b1;
    end else if (xfer) begin
      duty_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_pend_q   <= '0;
      duty_active_q <= '0;
      duty_busy_q   <= 1'b0;
      period_tick_q <= 1'b0;
    end else begin
      duty_pend_q   <= duty_pend_d;
      duty_active_q <= duty_active_d;
      duty_busy_q   <= duty_busy_d;
      period_tick_q <= period_tick_d;
    end
  end

  assign duty_busy   = duty_busy_q;
  assign period_tick = period_tick_q;

`ifdef DEADBAND_DEADTIME_EN

  typedef enum logic [1:0] {
    S_LOW,
    S_DT_HI,
    S_HIGH,
    S_DT_LO
  } state_t;

  state_t       state_q, state_d;
  logic [D-1:0] dt_cnt_q, dt_cnt_d;
  logic         dt_done;

  // Widened compare so dead_time = 0 (changed mid-band) ends the band at once.
  assign dt_done = ({1'b0, dt_cnt_q} + (D+1)'(1)) >= {1'b0, dead_time};

  always_comb begin
    state_d  = state_q;
    dt_cnt_d = dt_cnt_q;
    out_hi   = 1'b0;
    out_lo   = 1'b0;
    case (state_q)
      S_LOW: begin
        out_lo = 1'b1;
        if (raw) begin
          dt_cnt_d = '0;
          state_d  = (dead_time != '0) ? S_DT_HI : S_HIGH;
        end
      end
      S_DT_HI: begin
        if (!raw) begin
          dt_cnt_d = '0;
          state_d  = S_LOW;
        end else if (dt_done) begin
          dt_cnt_d = '0;
          state_d  = S_HIGH;
        end else begin
          dt_cnt_d = dt_cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        out_hi = 1'b1;
        if (!raw) begin
          dt_cnt_d = '0;
          state_d  = (dead_time != '0) ? S_DT_LO : S_LOW;
        end
      end
      S_DT_LO: begin
        if (raw) begin
          dt_cnt_d = '0;
          state_d  = S_HIGH;
        end else if (dt_done) begin
          dt_cnt_d = '0;
          state_d  = S_LOW;
        end else begin
          dt_cnt_d = dt_cnt_q + 1'b1;
        end
      end
      default: begin
        dt_cnt_d = '0;
        state_d  = S_DT_LO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_DT_LO;
      dt_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      dt_cnt_q <= dt_cnt_d;
    end
  end

`else

  logic out_hi_q;
  logic unused_dead_time;

  assign unused_dead_time = ^dead_time;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_hi_q <= 1'b0;
    end else begin
      out_hi_q <= raw;
    end
  end

  assign out_hi = out_hi_q;
  assign out_lo = ~out_hi_q;

`endif

endmodule

// File: tb/tb_pwm_deadband.sv
// Randomized and directed bench for pwm_deadband against a cycle-level reference model.
module tb_pwm_deadband;
  localparam int N = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst, ena, duty_load;
  logic [N-1:0] tri_in, duty_in;
  logic [D-1:0] dead_time;
  logic         duty_busy, period_tick, out_hi, out_lo;

  always #5 clk = ~clk;

  pwm_deadband #(.N(N), .D(D)) dut (
    .clk(clk), .rst(rst), .ena(ena), .tri_in(tri_in), .duty_in(duty_in),
    .duty_load(duty_load), .dead_time(dead_time), .duty_busy(duty_busy),
    .period_tick(period_tick), .out_hi(out_hi), .out_lo(out_lo)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int m_pend, m_active, m_busy, m_tick, m_hi, m_lo;
  int m_mode;   // 0 low, 1 going-high band, 2 high, 3 going-low band
  int m_elap;   // dead cycles already spent in the current band
  // Upstream carrier.
  int tri_v = 100, tri_up = 1, peak = 255;
  int tick_seen, hi_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit ld, input int dv, input int dt);
    int  n_pend, n_active, n_busy, n_tick, n_mode, n_elap;
    bit  raw, xfer;
    rst = r; ena = e; duty_load = ld;
    duty_in = N'(dv); dead_time = D'(dt); tri_in = N'(tri_v);
    raw  = tri_v < m_active;
    xfer = (m_busy == 1) && e && (tri_v == 0);
    n_active = xfer ? m_pend : m_active;
    n_tick   = xfer ? 1 : 0;
    n_pend   = ld ? dv : m_pend;
    n_busy   = ld ? 1 : (xfer ? 0 : m_busy);
    n_mode = m_mode; n_elap = m_elap;
    case (m_mode)
      0: if (raw) begin n_mode = (dt != 0) ? 1 : 2; n_elap = 0; end
      2: if (!raw) begin n_mode = (dt != 0) ? 3 : 0; n_elap = 0; end
      1: if (!raw) begin n_mode = 0; n_elap = 0; end
         else if (m_elap + 1 >= dt) begin n_mode = 2; n_elap = 0; end
         else n_elap = m_elap + 1;
      default: if (raw) begin n_mode = 2; n_elap = 0; end
         else if (m_elap + 1 >= dt) begin n_mode = 0; n_elap = 0; end
         else n_elap = m_elap + 1;
    endcase
    if (r) begin
      n_pend = 0; n_active = 0; n_busy = 0; n_tick = 0; n_mode = 3; n_elap = 0;
    end
`ifdef DEADBAND_DEADTIME_EN
    m_hi = (n_mode == 2) ? 1 : 0;
    m_lo = (n_mode == 0) ? 1 : 0;
`else
    m_hi = (!r && raw) ? 1 : 0;
    m_lo = 1 - m_hi;
`endif
    m_pend = n_pend; m_active = n_active; m_busy = n_busy; m_tick = n_tick;
    m_mode = n_mode; m_elap = n_elap;
    if (e) begin
      if (tri_up == 1) begin
        if (tri_v >= peak) begin tri_up = 0; tri_v--; end else tri_v++;
      end else begin
        if (tri_v == 0) begin tri_up = 1; tri_v++; end else tri_v--;
      end
    end
    @(posedge clk); #1;
    chk("duty_busy", 32'(duty_busy), 32'(m_busy));
    chk("period_tick", 32'(period_tick), 32'(m_tick));
    chk("out_hi", 32'(out_hi), 32'(m_hi));
    chk("out_lo", 32'(out_lo), 32'(m_lo));
    chk("no_overlap", 32'(out_hi & out_lo), 32'd0);
    if (period_tick === 1'b1) tick_seen++;
    if (out_hi === 1'b1) hi_seen++;
  endtask

  task automatic run(input int n, input int dt);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, dt);
  endtask

  task automatic set_peak(input int p);
    peak = p; tri_v = 0; tri_up = 1;
  endtask

  initial begin
    rst = 1; ena = 0; duty_load = 0; duty_in = '0; dead_time = '0; tri_in = '0;
    m_pend = 0; m_active = 0; m_busy = 0; m_tick = 0; m_hi = 0; m_lo = 0;
    m_mode = 3; m_elap = 0;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 2);

    // Duty 64 with ena every cycle: one tick at the valley, then high for tri < 64.
    tick_seen = 0;
    step(0, 1, 1, 64, 0);
    run(600, 0);
    chk("tick_once_64", 32'(tick_seen), 32'd1);
    hi_seen = 0;
    run(510, 0);
    chk("hi_count_64", 32'(hi_seen), 32'd127);

    // Two loads before the valley: the later one wins, single tick.
    tri_v = 100; tri_up = 1; tick_seen = 0;
    step(0, 1, 1, 10, 0);
    run(5, 0);
    step(0, 1, 1, 20, 0);
    run(500, 0);
    chk("tick_once_20", 32'(tick_seen), 32'd1);
    hi_seen = 0;
    run(510, 0);
    chk("hi_count_20", 32'(hi_seen), 32'd39);

    // Dead time 3 across full edges.
    set_peak(20);
    step(0, 1, 1, 10, 3);
    run(120, 3);

    // Dead time 5 against a 3-cycle raw pulse: high side never fires.
    step(0, 1, 1, 2, 5);
    run(60, 5);
    hi_seen = 0;
    run(40, 5);
`ifdef DEADBAND_DEADTIME_EN
    chk("short_pulse_hi", 32'(hi_seen), 32'd0);
`else
    chk("short_pulse_hi", 32'(hi_seen), 32'd3);
`endif

    // Reset during a going-high band, then dead_time 2 after release.
    step(0, 1, 1, 15, 6);
    run(60, 6);
    while (tri_v != 14) step(0, 1, 0, 0, 6);
    step(0, 1, 0, 0, 6);
    step(1, 1, 0, 0, 2);
    chk("rst_mid_hi", 32'(out_hi), 32'd0);
    step(0, 1, 0, 0, 2);
    step(0, 1, 0, 0, 2);
    chk("post_rst_lo", 32'(out_lo), 32'd1);

    // Duty 0 never drives high; duty 255 on a 128 peak always does.
    set_peak(255);
    step(0, 1, 1, 0, 1);
    run(520, 1);
    hi_seen = 0;
    run(510, 1);
    chk("duty0_hi", 32'(hi_seen), 32'd0);
    set_peak(128);
    step(0, 1, 1, 255, 1);
    run(300, 1);
    hi_seen = 0;
    run(256, 1);
    chk("duty255_hi", 32'(hi_seen), 32'd256);

    // Random mix of ena gaps, reloads, dead-time changes, peaks and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        case ($urandom_range(0, 2))
          0: set_peak(20);
          1: set_peak(128);
          default: set_peak(255);
        endcase
      end
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0, int'($urandom_range(0, 255)),
           int'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
